// File: rtl/tune_sequencer_pkg.sv
// Shared constants and types for the tune sequencer and its tick generator.
package tune_sequencer_pkg;

   // Signal generator register map (0-5) plus the two sequencer registers (6-7).
   localparam logic [2:0] PERIOD_A = 3'd0;
   localparam logic [2:0] PERIOD_B = 3'd1;
   localparam logic [2:0] VOL_A    = 3'd2;
   localparam logic [2:0] VOL_B    = 3'd3;
   localparam logic [2:0] VOL_N    = 3'd4;
   localparam logic [2:0] ENABLES  = 3'd5;
   localparam logic [2:0] SEQ_CTRL = 3'd6;
   localparam logic [2:0] SEQ_PAT  = 3'd7;

   localparam logic [4:0] VOL_REST = 5'd0;
   localparam logic [4:0] VOL_FULL = 5'd15;

   localparam int unsigned TEMPO_BITS = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWrPer,
      StWrVol,
      StWait
   } seq_state_e;

endpackage

// File: rtl/tune_sequencer_tempo_ticker.sv
// Prescaler plus tempo counter; step_tick fires once every (tempo+1) base ticks.
module tempo_ticker
   import tune_sequencer_pkg::*;
#(
   parameter int unsigned PRESCALE_BITS = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [TEMPO_BITS-1:0] tempo,
   output logic                  step_tick
);

   logic [PRESCALE_BITS-1:0] prescale_q;
   logic [TEMPO_BITS-1:0]    count_q;
   logic                     base_tick;

   // Base tick on prescaler wrap; step tick when the tempo count has been reached.
   always_comb begin
      base_tick = &prescale_q;
      step_tick = base_tick && (count_q == tempo);
   end

   // Prescaler and tempo counter, held at zero while cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q <= '0;
         count_q    <= '0;
      end else if (clear) begin
         prescale_q <= '0;
         count_q    <= '0;
      end else begin
         prescale_q <= prescale_q + PRESCALE_BITS'(1);
         if (base_tick) begin
            count_q <= (count_q == tempo) ? '0 : count_q + TEMPO_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/tune_sequencer.sv
// Tune sequencer: forwards host writes to the signal generator and plays an
// 8-entry period pattern as (period, volume) register write pairs.
module tune_sequencer
   import tune_sequencer_pkg::*;
#(
   parameter int unsigned PRESCALE_BITS = 12,
   parameter int unsigned NUM_STEPS     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       host_strobe,
   input  logic [2:0] host_addr,
   input  logic [4:0] host_data,
   output logic       gen_strobe,
   output logic [2:0] gen_addr,
   output logic [4:0] gen_data,
   output logic [2:0] seq_step,
   output logic       seq_running,
   output logic       host_collision
);

   seq_state_e                  state_q, state_d;
   logic                        run_q;
   logic [TEMPO_BITS-1:0]       tempo_q;
   logic [2:0]                  load_ptr_q;
   logic [2:0]                  step_ptr_q, step_ptr_d;
   logic [NUM_STEPS-1:0][4:0]   pattern_q;
   logic                        gen_strobe_q, gen_strobe_d;
   logic [2:0]                  gen_addr_q, gen_addr_d;
   logic [4:0]                  gen_data_q, gen_data_d;
   logic [2:0]                  seq_step_q, seq_step_d;
   logic                        collision_q, collision_d;
   logic                        host_fwd, host_stop, step_tick;
   logic [4:0]                  cur_entry;

   tempo_ticker #(
      .PRESCALE_BITS (PRESCALE_BITS)
   ) u_ticker (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state_q == StIdle),
      .tempo     (tempo_q),
      .step_tick (step_tick)
   );

   // Host decode: generator writes are forwarded, a run=0 control write stops play.
   always_comb begin
      host_fwd  = host_strobe && (host_addr < SEQ_CTRL);
      host_stop = host_strobe && (host_addr == SEQ_CTRL) && !host_data[4];
      cur_entry = pattern_q[step_ptr_q];
   end

   // Next-state and generator bus mux; host writes win, sequencer writes stall and retry.
   always_comb begin
      state_d      = state_q;
      step_ptr_d   = step_ptr_q;
      seq_step_d   = seq_step_q;
      gen_strobe_d = 1'b0;
      gen_addr_d   = gen_addr_q;
      gen_data_d   = gen_data_q;
      collision_d  = 1'b0;

      if (host_fwd) begin
         gen_strobe_d = 1'b1;
         gen_addr_d   = host_addr;
         gen_data_d   = host_data;
      end

      unique case (state_q)
         StIdle: begin
            step_ptr_d = '0;
            if (run_q) state_d = StWrPer;
         end
         StWrPer: begin
            if (host_fwd) begin
               collision_d = 1'b1;
            end else if (!host_stop) begin
               gen_strobe_d = 1'b1;
               gen_addr_d   = PERIOD_A;
               gen_data_d   = cur_entry;
               state_d      = StWrVol;
            end
         end
         StWrVol: begin
            if (host_fwd) begin
               collision_d = 1'b1;
            end else if (!host_stop) begin
               gen_strobe_d = 1'b1;
               gen_addr_d   = VOL_A;
               gen_data_d   = (cur_entry != 5'd0) ? VOL_FULL : VOL_REST;
               seq_step_d   = step_ptr_q;
               step_ptr_d   = step_ptr_q + 3'd1;
               state_d      = StWait;
            end
         end
         StWait: begin
            if (step_tick) state_d = StWrPer;
         end
         default: state_d = StIdle;
      endcase

      // A stop abandons whatever the sequencer was about to issue.
      if (host_stop) state_d = StIdle;
   end

   // Sequencer control and pattern registers written by the host.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= 1'b0;
         tempo_q    <= '0;
         load_ptr_q <= '0;
         pattern_q  <= '0;
      end else if (host_strobe && (host_addr == SEQ_CTRL)) begin
         run_q      <= host_data[4];
         tempo_q    <= host_data[3:0];
         load_ptr_q <= '0;
      end else if (host_strobe && (host_addr == SEQ_PAT)) begin
         pattern_q[load_ptr_q] <= host_data;
         load_ptr_q            <= load_ptr_q + 3'd1;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         step_ptr_q   <= '0;
         seq_step_q   <= '0;
         gen_strobe_q <= 1'b0;
         gen_addr_q   <= '0;
         gen_data_q   <= '0;
         collision_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_ptr_q   <= step_ptr_d;
         seq_step_q   <= seq_step_d;
         gen_strobe_q <= gen_strobe_d;
         gen_addr_q   <= gen_addr_d;
         gen_data_q   <= gen_data_d;
         collision_q  <= collision_d;
      end
   end

   assign gen_strobe     = gen_strobe_q;
   assign gen_addr       = gen_addr_q;
   assign gen_data       = gen_data_q;
   assign seq_step       = seq_step_q;
   assign seq_running    = run_q;
   assign host_collision = collision_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with a 16-cycle base tick.
module tb_tune_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       host_strobe;
   logic [2:0] host_addr;
   logic [4:0] host_data;
   logic       gen_strobe;
   logic [2:0] gen_addr;
   logic [4:0] gen_data;
   logic [2:0] seq_step;
   logic       seq_running;
   logic       host_collision;

   int checks   = 0;
   int failures = 0;

   tune_sequencer #(
      .PRESCALE_BITS (4),
      .NUM_STEPS     (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .host_strobe    (host_strobe),
      .host_addr      (host_addr),
      .host_data      (host_data),
      .gen_strobe     (gen_strobe),
      .gen_addr       (gen_addr),
      .gen_data       (gen_data),
      .seq_step       (seq_step),
      .seq_running    (seq_running),
      .host_collision (host_collision)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One host write, sampled on the next rising edge.
   task automatic wr(input logic [2:0] a, input logic [4:0] d);
      host_strobe = 1'b1;
      host_addr   = a;
      host_data   = d;
      tick();
      host_strobe = 1'b0;
   endtask

   task automatic expect_wr(input string tag, input logic [2:0] a, input logic [4:0] d);
      check({tag, "_strobe"}, gen_strobe, 1);
      check({tag, "_addr"}, gen_addr, a);
      check({tag, "_data"}, gen_data, d);
   endtask

   // Count cycles until the next period write, bounded by limit.
   task automatic wait_per(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(gen_strobe === 1'b1 && gen_addr === 3'd0) && n < limit);
   endtask

   initial begin
      logic [4:0] pat [8];
      logic [4:0] vol [8];
      int n;
      int strobes;
      pat = '{5'd1, 5'd2, 5'd0, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
      vol = '{5'd15, 5'd15, 5'd0, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15};

      rst_n = 1'b0;
      host_strobe = 1'b0;
      host_addr = '0;
      host_data = '0;
      repeat (3) tick();
      check("rst_strobe", gen_strobe, 0);
      check("rst_addr", gen_addr, 0);
      check("rst_data", gen_data, 0);
      check("rst_step", seq_step, 0);
      check("rst_running", seq_running, 0);
      check("rst_collision", host_collision, 0);
      rst_n = 1'b1;
      tick();

      // Plain forwarding of a generator write.
      wr(3'd3, 5'd9);
      expect_wr("fwd", 3'd3, 5'd9);
      check("fwd_running", seq_running, 0);
      tick();
      check("fwd_strobe_drop", gen_strobe, 0);
      check("fwd_addr_hold", gen_addr, 3);
      check("fwd_data_hold", gen_data, 9);

      // Load pattern; these writes are not forwarded.
      for (int i = 0; i < 8; i++) wr(3'd7, pat[i]);
      check("pat_not_fwd", gen_strobe, 0);

      // Start, tempo 0: one step every 16 cycles, nine steps to see the wrap.
      wr(3'd6, 5'h10);
      check("run_set", seq_running, 1);
      check("start_quiet", gen_strobe, 0);
      tick();
      tick();
      for (int s = 0; s < 9; s++) begin
         expect_wr($sformatf("per%0d", s), 3'd0, pat[s % 8]);
         tick();
         expect_wr($sformatf("vol%0d", s), 3'd2, vol[s % 8]);
         check($sformatf("step%0d", s), seq_step, s % 8);
         if (s != 8) repeat (15) tick();
      end

      // Host write lands in the WR_PER cycle: host wins, sequencer retries.
      repeat (14) tick();
      wr(3'd1, 5'd7);
      expect_wr("coll_host", 3'd1, 5'd7);
      check("coll_pulse", host_collision, 1);
      tick();
      expect_wr("coll_retry", 3'd0, 5'd2);
      check("coll_pulse_end", host_collision, 0);
      tick();
      expect_wr("coll_vol", 3'd2, 5'd15);
      check("coll_step", seq_step, 1);

      // Stop during WR_VOL: the volume write is dropped.
      repeat (14) tick();
      expect_wr("stop_per", 3'd0, 5'd0);
      wr(3'd6, 5'h00);
      check("stop_no_vol", gen_strobe, 0);
      check("stop_addr_hold", gen_addr, 0);
      check("stop_running", seq_running, 0);
      strobes = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (gen_strobe === 1'b1) strobes++;
      end
      check("stop_silent", strobes, 0);

      // Rerun with tempo 3 restarts at step 0, period writes 64 cycles apart.
      wr(3'd6, 5'h13);
      tick();
      tick();
      expect_wr("rerun_per", 3'd0, 5'd1);
      tick();
      expect_wr("rerun_vol", 3'd2, 5'd15);
      check("rerun_step", seq_step, 0);
      tick();
      check("rerun_gap", gen_strobe, 0);
      wait_per(200, n);
      check("tempo3_gap_a", n + 2, 64);
      check("tempo3_data_a", gen_data, 2);
      wait_per(200, n);
      check("tempo3_gap_b", n, 64);
      check("tempo3_data_b", gen_data, 0);
      tick();
      check("tempo3_step", seq_step, 2);

      // Reset for one cycle in WAIT.
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("mrst_strobe", gen_strobe, 0);
      check("mrst_addr", gen_addr, 0);
      check("mrst_data", gen_data, 0);
      check("mrst_step", seq_step, 0);
      check("mrst_running", seq_running, 0);
      tick();
      rst_n = 1'b1;
      strobes = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (gen_strobe === 1'b1) strobes++;
      end
      check("mrst_silent", strobes, 0);

      // Cleared pattern plays as a rest.
      wr(3'd6, 5'h10);
      tick();
      tick();
      expect_wr("clr_per", 3'd0, 5'd0);
      tick();
      expect_wr("clr_vol", 3'd2, 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tune_sequencer.md
TUNE_SEQUENCER -- requirements
Module: tune_sequencer

Interface
REQ-001 Parameter PRESCALE_BITS, default 12, sets the base-tick period to 2^PRESCALE_BITS clk cycles.
REQ-002 Parameter NUM_STEPS, default 8, is fixed at 8 and matches the 3-bit step index.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 host_strobe  input  1  host register-write strobe, one write per high cycle.
REQ-006 host_addr  input  3  host write address; 0-5 are generator registers, 6-7 are sequencer registers.
REQ-007 host_data  input  5  host write data.
REQ-008 gen_strobe  output  1  write strobe to the signal generator register bus.
REQ-009 gen_addr  output  3  address to the signal generator.
REQ-010 gen_data  output  5  data to the signal generator.
REQ-011 seq_step  output  3  index of the pattern entry most recently issued.
REQ-012 seq_running  output  1  run bit as currently held.
REQ-013 host_collision  output  1  one-cycle pulse when a sequencer write is stalled by a host write.

Function
REQ-014 Host write to addr 0-5 is forwarded unchanged on gen_* exactly 1 cycle later with gen_strobe=1; it has absolute priority.
REQ-015 Host write to addr 6 sets run=data[4] and tempo=data[3:0], resets load pointer to 0, and is not forwarded.
REQ-016 Host write to addr 7 stores data in pattern[load_ptr], then load_ptr increments mod 8; it is not forwarded.
REQ-017 Tick generator: PRESCALE_BITS-bit prescaler wraps to a base tick; tempo counter counts base ticks; step tick fires when counter==tempo and counter clears. Step period = (tempo+1)*2^PRESCALE_BITS cycles.
REQ-018 FSM states: IDLE, WR_PER, WR_VOL, WAIT.
REQ-019 IDLE: prescaler, tempo counter and step pointer held at 0; on run 0->1 go to WR_PER next cycle.
REQ-020 WR_PER: issue write addr 0, data=pattern[step_ptr]; then WR_VOL.
REQ-021 WR_VOL: issue write addr 2, data=15 if pattern[step_ptr]!=0 else 0 (entry 0 = rest); seq_step<=step_ptr, step_ptr increments mod 8 (wraps 7->0); then WAIT.
REQ-022 WAIT: on step tick go to WR_PER.
REQ-023 A sequencer write cycle coinciding with a forwarded host write (addr 0-5) is not issued; FSM holds state, host_collision pulses, write is retried next cycle.
REQ-024 Step ticks occurring outside WAIT are dropped; the tick generator keeps running in all non-IDLE states.
REQ-025 Write of run=0 (addr 6) moves FSM to IDLE the next cycle from any state, abandoning any unissued write; no partial write is emitted after that cycle.
REQ-026 Write to addr 6 with run=1 while running updates tempo only; FSM and counters unaffected.
REQ-027 gen_strobe is high for at most one write per cycle; gen_addr/gen_data hold last value when gen_strobe=0.
REQ-028 All outputs are registered.

Reset
REQ-029 rst_n low asynchronously clears: FSM to IDLE, run, tempo, load_ptr, step_ptr, prescaler, tempo counter, all 8 pattern entries, gen_strobe, gen_addr, gen_data, seq_step, host_collision to 0.
REQ-030 Reset mid-sequence abandons any pending write; no gen_strobe occurs until a new host or sequencer write after release.

Structure
REQ-031 Shared package holds register address constants (PERIOD_A=0, PERIOD_B=1, VOL_A=2, VOL_B=3, VOL_N=4, ENABLES=5, SEQ_CTRL=6, SEQ_PAT=7), rest volume/full volume constants, and FSM state type.
REQ-032 One sub-module, tempo_ticker (prescaler plus tempo counter, clear input, step-tick output), is instantiated.

Verification
REQ-033 Host write addr 3 data 9 -> next cycle gen_strobe=1, gen_addr=3, gen_data=9; no sequencer activity.
REQ-034 Load pattern 1,2,0,4,5,6,7,8 via addr 7, write addr 6 data 0x10 (PRESCALE_BITS=4) -> writes (0,1),(2,15) immediately, then every 16 cycles (0,entry),(2,15 or 0); step 2 gives (2,0); step 7 wraps to entry 0.
REQ-035 Tempo 3, PRESCALE_BITS=4 -> WR_PER strobes spaced exactly 64 cycles.
REQ-036 Host write addr 1 in same cycle sequencer is in WR_PER -> host write forwarded, host_collision=1, sequencer write (0,entry) appears one cycle later.
REQ-037 Write addr 6 data 0 during WR_VOL -> no volume write issued, FSM IDLE, seq_running=0; rerun restarts at step 0.
REQ-038 rst_n low for one cycle mid-WAIT -> all outputs 0, pattern cleared, seq_running=0.
